// File: rtl/controller_input.sv
// controller_input: debounced, refresh-aligned button levels with press/release/auto-repeat pulses
// Ports: clk, rst (async, active-high), refresh (frame strobe), buttons_raw (async pins, 1 = pressed);
// buttons_held (debounced level at last refresh), buttons_pressed/buttons_released/buttons_move
// (one-cycle per-frame pulses), frame_valid (marks the cycle the pulses are valid).
module controller_input #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_RATE     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   refresh,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_held,
  output logic [NUM_BUTTONS-1:0] buttons_pressed,
  output logic [NUM_BUTTONS-1:0] buttons_released,
  output logic [NUM_BUTTONS-1:0] buttons_move,
  output logic                   frame_valid
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE + 1);
  logic [NUM_BUTTONS-1:0] s1, sync, stable, press_pend, rel_pend;
  logic [NUM_BUTTONS-1:0] rise_now, fall_now, stable_nx, press_del, move_nx;
  logic [DW-1:0] dcnt [NUM_BUTTONS];
  logic [DW-1:0] dcnt_nx [NUM_BUTTONS];
  logic [RW-1:0] rcnt [NUM_BUTTONS];
  logic [RW-1:0] rcnt_nx [NUM_BUTTONS];
  // stable_nx is the level after any same-cycle debounced edge, so an edge landing
  // on the refresh cycle is folded into that frame's snapshot and pulses.
  always_comb begin
    rise_now  = '0;
    fall_now  = '0;
    stable_nx = '0;
    press_del = '0;
    move_nx   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      rise_now[i]  = sync[i] & ~stable[i] & (dcnt[i] == D_MAX);
      fall_now[i]  = ~sync[i] & stable[i] & (dcnt[i] == D_MAX);
      stable_nx[i] = (rise_now[i] | fall_now[i]) ? sync[i] : stable[i];
      dcnt_nx[i]   = (sync[i] == stable[i] || dcnt[i] == D_MAX) ? '0 : dcnt[i] + 1'b1;
      press_del[i] = press_pend[i] | rise_now[i];
      move_nx[i]   = press_del[i] | (stable_nx[i] & (rcnt[i] == R_MAX));
      rcnt_nx[i]   = press_del[i]          ? RW'(stable_nx[i]) :
                     !stable_nx[i]         ? '0 :
                     (rcnt[i] == R_MAX)    ? R_RELOAD : rcnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1               <= '0;
      sync             <= '0;
      stable           <= '0;
      press_pend       <= '0;
      rel_pend         <= '0;
      dcnt             <= '{default: '0};
      rcnt             <= '{default: '0};
      buttons_held     <= '0;
      buttons_pressed  <= '0;
      buttons_released <= '0;
      buttons_move     <= '0;
      frame_valid      <= 1'b0;
    end else begin
      s1          <= buttons_raw;
      sync        <= s1;
      stable      <= stable_nx;
      dcnt        <= dcnt_nx;
      frame_valid <= refresh;
      if (refresh) begin
        press_pend       <= '0;
        rel_pend         <= '0;
        rcnt             <= rcnt_nx;
        buttons_held     <= stable_nx;
        buttons_pressed  <= press_del;
        buttons_released <= rel_pend | fall_now;
        buttons_move     <= move_nx;
      end else begin
        press_pend       <= press_pend | rise_now;
        rel_pend         <= rel_pend | fall_now;
        buttons_pressed  <= '0;
        buttons_released <= '0;
        buttons_move     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_controller_input.sv
// tb_controller_input: directed stimulus with a frame scoreboard for controller_input
module tb_controller_input;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh = 1'b0;
  logic [3:0] buttons_raw = '0;
  logic [3:0] buttons_held, buttons_pressed, buttons_released, buttons_move;
  logic       frame_valid;
  logic       done = 1'b0;
  logic [15:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;

  controller_input #(.NUM_BUTTONS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .buttons_raw(buttons_raw),
    .buttons_held(buttons_held), .buttons_pressed(buttons_pressed),
    .buttons_released(buttons_released), .buttons_move(buttons_move),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // {held, pressed, released, move} expected at each refresh (frame k at p = 20k)
  localparam logic [15:0] EXP [17] = '{
    16'h2202, 16'h0020, 16'h4404, 16'h4000, 16'h4000, 16'h4004, 16'h4000, 16'h4004,
    16'h4000, 16'h4004, 16'h0040, 16'h0888, 16'h0000, 16'h1101, 16'h1000, 16'h1101,
    16'h0010
  };

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // p = index of the rising edge that samples the inputs driven here
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int p = 1; p <= 350; p++) begin
      @(negedge clk);
      buttons_raw[0] = (p >= 3 && p <= 5) || (p >= 275 && p < 330);
      buttons_raw[1] = (p >= 8 && p < 30);
      buttons_raw[2] = (p >= 45 && p < 205);
      buttons_raw[3] = (p >= 222 && p < 230);
      refresh = (p % 20 == 0);
      if (refresh) sb.push_back(EXP[p/20 - 1]);
      if (p == 310) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    logic [3:0]  cur_held;
    logic [15:0] e;
    cur_held = '0;
    while (!done) begin
      @(negedge clk or posedge rst);
      if (rst) begin
        #1;
        chk("reset", {buttons_held, buttons_pressed, buttons_released, buttons_move, frame_valid}, 17'h0);
        cur_held = '0;
      end else if (frame_valid) begin
        if (sb.size() == 0) chk("unexpected_frame", {1'b0, buttons_held, buttons_pressed, buttons_released, buttons_move}, 17'h1ffff);
        else begin
          e = sb.pop_front();
          chk("frame", {1'b0, buttons_held, buttons_pressed, buttons_released, buttons_move}, {1'b0, e});
          cur_held = e[15:12];
        end
      end else
        chk("idle", {1'b0, buttons_held, buttons_pressed, buttons_released, buttons_move}, {1'b0, cur_held, 12'h0});
    end
    chk("drain", 17'(sb.size()), 17'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
